lns_add_pipe: RTL and testbench
===============================

// Module: lns_add_pipe
// PURPOSE
//  Pipelined log-number-system add/subtract unit; the producer/consumer side of the delta function.
//  Forms diff = |x_log - y_log| and the effective sign, applies delta_plus/delta_minus, and adds to max log.
//  3-stage pipeline with valid/ready handshake; feeds LNS datapaths that need a stream of sums.
// PARAMETERS
//  WBITS     `WBITS     total width of signed fixed-point log value
//  FRACBITS  `FRACBITS  fractional bits of log value (ONE = 1<<FRACBITS, ONE_PT_FIVE = 3<<(FRACBITS-1))
// PORTS
//  clk        in   1      clock, all state on rising edge
//  rst_n      in   1      synchronous active-low reset
//  in_valid   in   1      operand pair valid
//  in_ready   out  1      unit accepts operands this cycle
//  op_sub     in   1      1: z = x - y (y sign inverted), 0: z = x + y
//  x_zero     in   1      x is exact zero (x_log/x_sgn ignored)
//  x_sgn      in   1      x sign (1 = negative)
//  x_log      in   WBITS  x log2 magnitude, signed fixed point
//  y_zero     in   1      as x_zero for y
//  y_sgn      in   1      as x_sgn for y
//  y_log      in   WBITS  as x_log for y
//  out_valid  out  1      result valid
//  out_ready  in   1      downstream accepts result
//  z_zero     out  1      result is exact zero
//  z_sgn      out  1      result sign
//  z_log      out  WBITS  result log value, saturated
//  z_sat      out  1      z_log was saturated this result
// BEHAVIOUR
//  Reset (rst_n=0 at edge): v1,v2,v3 <= 0; out_valid, z_zero, z_sgn, z_log, z_sat <= 0. In-flight ops discarded.
//  Handshake: adv = out_ready | ~v3; in_ready = adv (combinational). Accept when in_valid & in_ready.
//   When adv=1, all stages shift one step (v1 <= in_valid&in_ready, v2 <= v1, v3 <= v2); else all hold.
//   Bubbles are not collapsed. out_valid = v3; z_* stay stable while out_valid & ~out_ready.
//  Latency: 3 cycles accept->out_valid with out_ready high; throughput 1/cycle.
//  S1: ys = y_sgn ^ op_sub. d = x_log - y_log in WBITS+1 bits signed. xbig = (d >= 0).
//   big_log/big_sgn from larger-log operand (x on tie); same = (x_sgn == ys); ad = |d| (WBITS+1 bits).
//   Zero handling: x_zero&y_zero -> zero result; x_zero only -> pass y (sign ys); y_zero only -> pass x.
//  S2: k = ad >> FRACBITS (integer part). If k > FRACBITS: delta = 0.
//   Else same: delta = ONE >> k;  else: delta = -(ONE_PT_FIVE >> k) (two's complement, WBITS+1).
//   Cancellation: ~same & ad == 0 -> zero result (z_zero=1, z_sgn=0, z_log=0).
//  S3: sum = big_log + delta in WBITS+1 bits; saturate to [-2^(WBITS-1), 2^(WBITS-1)-1], z_sat=1 if clipped.
//   z_sgn = big_sgn. Zero results: z_zero=1, z_sgn=0, z_log=0, z_sat=0. Pass-through: z_log = operand log, z_sat=0.
//  Reset asserted while out_valid & ~out_ready: result dropped; reset wins over any handshake that cycle.
// TESTING  (WBITS=16, FRACBITS=8; ONE=0x0100, ONE_PT_FIVE=0x0180)
//  1 add x=+0x0200 y=+0x0200 -> d=0, delta=+0x0100 -> z=+0x0300, out_valid 3 cycles after accept.
//  2 add x=+0x0500 y=-0x0200 -> k=3, delta=-0x0030 -> z=+0x04D0, z_sat=0.
//  3 sub x=+0x0200 y=+0x0200 -> z_zero=1, z_log=0; add x=+0x1000 y=+0x0000 -> k=16>8 -> z=+0x1000.
//  4 add x=+0x7F00 y=+0x7F00 -> sum 0x8000 clipped -> z_log=0x7FFF, z_sat=1; x_zero=1 y=-0x0300 sub -> z=+0x0300.
//  5 stream 6 ops back-to-back, out_ready=0 for 5 cycles after first out_valid -> in_ready=0 during stall,
//    z_* held stable, all 6 results delivered in order, none lost or duplicated.
//  6 3 ops in flight, rst_n=0 one cycle -> out_valid=0 next cycle, no stale result emerges later.

Source files
------------

// File: rtl/lns_add_pipe_if.sv
// Operand/result stream bundle for the LNS add/subtract pipeline.
// master = producer/consumer side, slave = the arithmetic unit.
interface lns_add_pipe_if #(
    parameter int WBITS = 16
);
    // upstream operand channel
    logic                    in_valid;
    logic                    in_ready;
    logic                    op_sub;
    logic                    x_zero;
    logic                    x_sgn;
    logic signed [WBITS-1:0] x_log;
    logic                    y_zero;
    logic                    y_sgn;
    logic signed [WBITS-1:0] y_log;
    // downstream result channel
    logic                    out_valid;
    logic                    out_ready;
    logic                    z_zero;
    logic                    z_sgn;
    logic signed [WBITS-1:0] z_log;
    logic                    z_sat;

    modport master (
        output in_valid, op_sub, x_zero, x_sgn, x_log, y_zero, y_sgn, y_log, out_ready,
        input  in_ready, out_valid, z_zero, z_sgn, z_log, z_sat
    );

    modport slave (
        input  in_valid, op_sub, x_zero, x_sgn, x_log, y_zero, y_sgn, y_log, out_ready,
        output in_ready, out_valid, z_zero, z_sgn, z_log, z_sat
    );
endinterface

// File: rtl/lns_add_pipe.sv
// Three-stage log-number-system add/subtract unit.
// Stage 1 orders the operands and forms |x_log - y_log|, stage 2 looks up the
// coarse delta correction, stage 3 adds it to the larger log and saturates.
// All stages advance together whenever the output stage is free or drained.
module lns_add_pipe #(
    parameter int WBITS    = 16,
    parameter int FRACBITS = 8
) (
    input logic              clk,
    input logic              rst_n,
    lns_add_pipe_if.slave    bus
);
    localparam int DW = WBITS + 1;

    localparam logic        [DW-1:0] ONE         = DW'(1) << FRACBITS;
    localparam logic        [DW-1:0] ONE_PT_FIVE = DW'(3) << (FRACBITS - 1);
    localparam logic signed [DW-1:0] MAXV        = DW'((1 << (WBITS - 1)) - 1);
    localparam logic signed [DW-1:0] MINV        = DW'(-(1 << (WBITS - 1)));

    // delta_plus / delta_minus approximation from the integer part of |d|
    function automatic logic signed [DW-1:0] delta_fn(input logic [DW-1:0] ad,
                                                      input logic          same);
        logic [DW-1:0] k;
        k = ad >> FRACBITS;
        if (k > DW'(FRACBITS))
            return '0;
        if (same)
            return $signed(ONE >> k);
        return -$signed(ONE_PT_FIVE >> k);
    endfunction

    // clamp to the WBITS signed range; MSB of the result flags a clip
    function automatic logic [WBITS:0] sat_fn(input logic signed [DW-1:0] s);
        if (s > MAXV)
            return {1'b1, MAXV[WBITS-1:0]};
        if (s < MINV)
            return {1'b1, MINV[WBITS-1:0]};
        return {1'b0, s[WBITS-1:0]};
    endfunction

    logic adv;

    // stage-1 registers
    logic                    vld_p1_q;
    logic                    zero_p1_q,    zero_p1_d;
    logic                    pass_p1_q,    pass_p1_d;
    logic                    same_p1_q,    same_p1_d;
    logic                    big_sgn_p1_q, big_sgn_p1_d;
    logic signed [WBITS-1:0] big_log_p1_q, big_log_p1_d;
    logic        [DW-1:0]    ad_p1_q,      ad_p1_d;

    // stage-2 registers
    logic                    vld_p2_q;
    logic                    zero_p2_q,    zero_p2_d;
    logic                    big_sgn_p2_q;
    logic signed [WBITS-1:0] big_log_p2_q;
    logic signed [DW-1:0]    delta_p2_q,   delta_p2_d;

    // stage-3 (output) registers
    logic                    vld_p3_q;
    logic                    z_zero_q,     z_zero_d;
    logic                    z_sgn_q,      z_sgn_d;
    logic signed [WBITS-1:0] z_log_q,      z_log_d;
    logic                    z_sat_q,      z_sat_d;

    logic                    ys;
    logic signed [DW-1:0]    d;
    logic                    xbig;
    logic signed [DW-1:0]    sum_p3;
    logic        [WBITS:0]   sat_p3;

    assign adv          = bus.out_ready | ~vld_p3_q;
    assign bus.in_ready = adv;

    // Stage 1: effective sign, log difference, larger operand, zero cases
    always_comb begin
        ys           = bus.y_sgn ^ bus.op_sub;
        d            = DW'(bus.x_log) - DW'(bus.y_log);
        xbig         = ~d[DW-1];
        ad_p1_d      = xbig ? d : -d;
        same_p1_d    = (bus.x_sgn == ys);
        zero_p1_d    = bus.x_zero & bus.y_zero;
        pass_p1_d    = bus.x_zero ^ bus.y_zero;
        big_log_p1_d = bus.x_log;
        big_sgn_p1_d = bus.x_sgn;
        if (bus.x_zero && !bus.y_zero) begin
            big_log_p1_d = bus.y_log;
            big_sgn_p1_d = ys;
        end else if (!bus.x_zero && !bus.y_zero && !xbig) begin
            big_log_p1_d = bus.y_log;
            big_sgn_p1_d = ys;
        end
    end

    // Stage 2: delta lookup and exact-cancellation detection
    always_comb begin
        delta_p2_d = (zero_p1_q | pass_p1_q) ? '0 : delta_fn(ad_p1_q, same_p1_q);
        zero_p2_d  = zero_p1_q | (~pass_p1_q & ~same_p1_q & (ad_p1_q == '0));
    end

    // Stage 3: accumulate delta onto the larger log and saturate
    always_comb begin
        sum_p3   = DW'(big_log_p2_q) + delta_p2_q;
        sat_p3   = sat_fn(sum_p3);
        z_zero_d = zero_p2_q;
        z_sgn_d  = zero_p2_q ? 1'b0 : big_sgn_p2_q;
        z_log_d  = zero_p2_q ? '0   : $signed(sat_p3[WBITS-1:0]);
        z_sat_d  = zero_p2_q ? 1'b0 : sat_p3[WBITS];
    end

    // Valid chain and output registers; reset drops everything in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
            vld_p3_q <= 1'b0;
            z_zero_q <= 1'b0;
            z_sgn_q  <= 1'b0;
            z_log_q  <= '0;
            z_sat_q  <= 1'b0;
        end else if (adv) begin
            vld_p1_q <= bus.in_valid;
            vld_p2_q <= vld_p1_q;
            vld_p3_q <= vld_p2_q;
            z_zero_q <= z_zero_d;
            z_sgn_q  <= z_sgn_d;
            z_log_q  <= z_log_d;
            z_sat_q  <= z_sat_d;
        end
    end

    // Intermediate datapath registers move with the valid chain, no reset needed
    always_ff @(posedge clk) begin
        if (adv) begin
            zero_p1_q    <= zero_p1_d;
            pass_p1_q    <= pass_p1_d;
            same_p1_q    <= same_p1_d;
            big_sgn_p1_q <= big_sgn_p1_d;
            big_log_p1_q <= big_log_p1_d;
            ad_p1_q      <= ad_p1_d;
            zero_p2_q    <= zero_p2_d;
            big_sgn_p2_q <= big_sgn_p1_q;
            big_log_p2_q <= big_log_p1_q;
            delta_p2_q   <= delta_p2_d;
        end
    end

    assign bus.out_valid = vld_p3_q;
    assign bus.z_zero    = z_zero_q;
    assign bus.z_sgn     = z_sgn_q;
    assign bus.z_log     = z_log_q;
    assign bus.z_sat     = z_sat_q;
endmodule

// File: tb/tb_lns_add_pipe.sv
// Directed bench for lns_add_pipe (WBITS=16, FRACBITS=8).
module tb_lns_add_pipe;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    lns_add_pipe_if #(.WBITS(16)) bus ();

    lns_add_pipe #(.WBITS(16), .FRACBITS(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic        op_sub;
        logic        x_zero;
        logic        x_sgn;
        logic [15:0] x_log;
        logic        y_zero;
        logic        y_sgn;
        logic [15:0] y_log;
        logic        e_zero;
        logic        e_sgn;
        logic [15:0] e_log;
        logic        e_sat;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs [NV];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic op, input logic xz, input logic xs, input logic [15:0] xl,
                                input logic yz, input logic ys, input logic [15:0] yl,
                                input logic ez, input logic es, input logic [15:0] el, input logic esat);
        vec_t v;
        v.op_sub = op; v.x_zero = xz; v.x_sgn = xs; v.x_log = xl;
        v.y_zero = yz; v.y_sgn = ys; v.y_log = yl;
        v.e_zero = ez; v.e_sgn = es; v.e_log = el; v.e_sat = esat;
        return v;
    endfunction

    task automatic drive(input int i);
        bus.op_sub = vecs[i].op_sub;
        bus.x_zero = vecs[i].x_zero;
        bus.x_sgn  = vecs[i].x_sgn;
        bus.x_log  = vecs[i].x_log;
        bus.y_zero = vecs[i].y_zero;
        bus.y_sgn  = vecs[i].y_sgn;
        bus.y_log  = vecs[i].y_log;
    endtask

    task automatic chk_res(input string tag, input int i, input logic zz, input logic zs,
                           input logic [15:0] zl, input logic zsat);
        chk($sformatf("%s_vec%0d_zero", tag, i), 32'(zz), 32'(vecs[i].e_zero));
        chk($sformatf("%s_vec%0d_sgn", tag, i), 32'(zs), 32'(vecs[i].e_sgn));
        chk($sformatf("%s_vec%0d_log", tag, i), 32'(zl), 32'(vecs[i].e_log));
        chk($sformatf("%s_vec%0d_sat", tag, i), 32'(zsat), 32'(vecs[i].e_sat));
    endtask

    task automatic run_vec(input int i);
        int lat;
        drive(i);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 10) begin
            tick();
            lat++;
        end
        chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd3);
        chk_res("single", i, bus.z_zero, bus.z_sgn, bus.z_log, bus.z_sat);
        tick();
    endtask

    logic        got_zero [6];
    logic        got_sgn  [6];
    logic [15:0] got_log  [6];
    logic        got_sat  [6];
    int          n_got;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
        $fatal(1);
    end

    initial begin
        //            op xz xs xl       yz ys yl       ez es el       sat
        vecs[0]  = mk(0, 0, 0, 16'h0200, 0, 0, 16'h0200, 0, 0, 16'h0300, 0);
        vecs[1]  = mk(0, 0, 0, 16'h0500, 0, 1, 16'h0200, 0, 0, 16'h04D0, 0);
        vecs[2]  = mk(1, 0, 0, 16'h0200, 0, 0, 16'h0200, 1, 0, 16'h0000, 0);
        vecs[3]  = mk(0, 0, 0, 16'h1000, 0, 0, 16'h0000, 0, 0, 16'h1000, 0);
        vecs[4]  = mk(0, 0, 0, 16'h7F00, 0, 0, 16'h7F00, 0, 0, 16'h7FFF, 1);
        vecs[5]  = mk(1, 1, 0, 16'h0000, 0, 1, 16'h0300, 0, 0, 16'h0300, 0);
        vecs[6]  = mk(0, 1, 1, 16'h1234, 1, 1, 16'h1234, 1, 0, 16'h0000, 0);
        vecs[7]  = mk(0, 0, 1, 16'h0123, 1, 0, 16'h5555, 0, 1, 16'h0123, 0);
        vecs[8]  = mk(0, 0, 0, 16'h8010, 0, 1, 16'h8000, 0, 0, 16'h8000, 1);
        vecs[9]  = mk(0, 0, 0, 16'h0100, 0, 0, 16'h0400, 0, 0, 16'h0420, 0);
        vecs[10] = mk(0, 0, 0, 16'h0900, 0, 0, 16'h0100, 0, 0, 16'h0901, 0);
        vecs[11] = mk(1, 0, 0, 16'h0900, 0, 0, 16'h0100, 0, 0, 16'h08FF, 0);
        vecs[12] = mk(0, 0, 0, 16'h0A00, 0, 0, 16'h0100, 0, 0, 16'h0A00, 0);
        vecs[13] = mk(1, 0, 0, 16'h0100, 0, 0, 16'h0300, 0, 1, 16'h02A0, 0);
        vecs[14] = mk(0, 0, 0, 16'h0280, 0, 0, 16'h0200, 0, 0, 16'h0380, 0);
        vecs[15] = mk(0, 0, 0, 16'hFF00, 0, 0, 16'hFE00, 0, 0, 16'hFF80, 0);

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        drive(0);
        tick();
        tick();
        chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset_z_zero", 32'(bus.z_zero), 32'd0);
        chk("reset_z_sgn", 32'(bus.z_sgn), 32'd0);
        chk("reset_z_log", 32'(bus.z_log), 32'd0);
        chk("reset_z_sat", 32'(bus.z_sat), 32'd0);
        chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < NV; i++)
            run_vec(i);

        // back-to-back stream with a 5-cycle downstream stall
        n_got         = 0;
        bus.out_ready = 1'b1;
        fork
            begin : producer
                int  pi;
                int  pc;
                logic acc;
                pi = 0;
                pc = 0;
                while (pi < 6 && pc < 100) begin
                    drive(pi);
                    bus.in_valid = 1'b1;
                    @(negedge clk);
                    acc = bus.in_ready;
                    @(posedge clk);
                    #1;
                    if (acc) pi++;
                    pc++;
                end
                bus.in_valid = 1'b0;
                chk("stream_all_accepted", 32'(pi), 32'd6);
            end
            begin : consumer
                int   cc;
                bit   stalled;
                logic [18:0] snap;
                cc      = 0;
                stalled = 1'b0;
                while (n_got < 6 && cc < 200) begin
                    @(negedge clk);
                    cc++;
                    if (bus.out_valid && bus.out_ready) begin
                        got_zero[n_got] = bus.z_zero;
                        got_sgn[n_got]  = bus.z_sgn;
                        got_log[n_got]  = bus.z_log;
                        got_sat[n_got]  = bus.z_sat;
                        n_got++;
                        if (!stalled) begin
                            stalled = 1'b1;
                            @(posedge clk);
                            #1;
                            bus.out_ready = 1'b0;
                            snap = '0;
                            for (int j = 0; j < 5; j++) begin
                                @(negedge clk);
                                if (j == 0)
                                    snap = {bus.z_zero, bus.z_sgn, bus.z_log, bus.z_sat};
                                chk($sformatf("stall%0d_out_valid", j), 32'(bus.out_valid), 32'd1);
                                chk($sformatf("stall%0d_in_ready", j), 32'(bus.in_ready), 32'd0);
                                chk($sformatf("stall%0d_hold", j),
                                    32'({bus.z_zero, bus.z_sgn, bus.z_log, bus.z_sat}), 32'(snap));
                                @(posedge clk);
                                #1;
                            end
                            bus.out_ready = 1'b1;
                        end
                    end
                end
                chk("stream_count", 32'(n_got), 32'd6);
            end
        join
        for (int i = 0; i < 6; i++)
            if (i < n_got)
                chk_res("stream", i, got_zero[i], got_sgn[i], got_log[i], got_sat[i]);
        tick();
        tick();
        chk("stream_no_extra", 32'(bus.out_valid), 32'd0);

        // reset with three operations in flight
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(9 + i);
            bus.in_valid = 1'b1;
            tick();
        end
        bus.in_valid = 1'b0;
        rst_n        = 1'b0;
        tick();
        chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
        chk("flush_z_log", 32'(bus.z_log), 32'd0);
        rst_n = 1'b1;
        begin
            int seen;
            seen = 0;
            for (int j = 0; j < 8; j++) begin
                tick();
                if (bus.out_valid) seen++;
            end
            chk("flush_no_stale", 32'(seen), 32'd0);
        end
        run_vec(13);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
